smol_muldiv: RTL and testbench

- Parametrised, multi-cycle integer multiply/divide unit for smolCore; the next generation of the single-cycle ALU datapath.
- Implements the eight RISC-V M-extension operations on WIDTH-bit operands. Uses one shared iterative shift/add-subtract engine (one bit per cycle).
- Sits beside the ALU in execute. Uses valid/ready handshakes on both sides so the pipeline stalls while an operation is in flight.

---
 rtl/smol_pkg.sv | 39 +++
 rtl/smol_md_step.sv | 37 +++
 rtl/smol_muldiv.sv | 153 +++++++++++++++
 tb/tb_smol_muldiv.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smol_pkg.sv
// Shared types and operation-decode helpers for the smolCore multiply/divide unit.
package smol_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic is_signed_a(input md_op_e op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

    // For divides the remainder lives in the upper half of the accumulator,
    // so REM/REMU count as "high" results alongside the MULH variants.
    function automatic logic returns_high(input md_op_e op);
        return op inside {MULH, MULHSU, MULHU, REM, REMU};
    endfunction

endpackage

// File: rtl/smol_md_step.sv
// One iteration of the shared engine: shift-add for multiply, restoring
// trial-subtract for divide, on a {hi, lo} accumulator.
module smol_md_step #(
    parameter int WIDTH = 32
) (
    input  logic               mode_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   trial;

    assign hi = acc_i[2*WIDTH-1:WIDTH];
    assign lo = acc_i[WIDTH-1:0];

    // Multiply keeps the multiplier in lo and shifts the product in from the top;
    // divide keeps the dividend in lo and shifts quotient bits in from the bottom.
    always_comb begin
        addSum   = lo[0] ? ({1'b0, hi} + {1'b0, opnd_i}) : {1'b0, hi};
        remShift = {hi, lo[WIDTH-1]};
        trial    = remShift - {1'b0, opnd_i};
        acc_o    = {addSum, lo[WIDTH-1:1]};
        if (mode_i) begin
            if (trial[WIDTH]) begin
                acc_o = {remShift[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {trial[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/smol_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit, one bit per cycle,
// with valid/ready handshakes on request and result sides.
module smol_muldiv
    import smol_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  md_op_e           op_sel,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] md_out,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          stateQ, stateD;
    md_op_e             opQ, opD;
    logic [CNT_W-1:0]   cntQ, cntD;
    logic [2*WIDTH-1:0] accQ, accD;
    logic [WIDTH-1:0]   opndQ, opndD;
    logic               negQ, negD;
    logic [WIDTH-1:0]   resultQ, resultD;
    logic               dbzQ, dbzD;

    logic               signA, signB, inIsDiv, inIsRem, divZero, divOvf;
    logic [WIDTH-1:0]   magA, magB;
    logic [2*WIDTH-1:0] stepAcc, prodSigned;
    logic [WIDTH-1:0]   divVal, divSigned, finalRes;

    always_comb begin
        inIsDiv = is_div(op_sel);
        inIsRem = inIsDiv && returns_high(op_sel);
        signA   = is_signed_a(op_sel) && rs1[WIDTH-1];
        signB   = is_signed_b(op_sel) && rs2[WIDTH-1];
        magA    = signA ? -rs1 : rs1;
        magB    = signB ? -rs2 : rs2;
        divZero = inIsDiv && (rs2 == '0);
        divOvf  = inIsDiv && is_signed_a(op_sel) && (rs1 == MinVal) && (rs2 == '1);
    end

    smol_md_step #(
        .WIDTH(WIDTH)
    ) uStep (
        .mode_i (is_div(opQ)),
        .acc_i  (accQ),
        .opnd_i (opndQ),
        .acc_o  (stepAcc)
    );

    // Sign fix-up happens on the last iteration's output so the result is
    // registered in the same cycle the FSM enters DONE.
    always_comb begin
        prodSigned = negQ ? -stepAcc : stepAcc;
        divVal     = returns_high(opQ) ? stepAcc[2*WIDTH-1:WIDTH] : stepAcc[WIDTH-1:0];
        divSigned  = negQ ? -divVal : divVal;
        if (is_div(opQ)) begin
            finalRes = divSigned;
        end else if (returns_high(opQ)) begin
            finalRes = prodSigned[2*WIDTH-1:WIDTH];
        end else begin
            finalRes = prodSigned[WIDTH-1:0];
        end
    end

    always_comb begin
        stateD  = stateQ;
        opD     = opQ;
        cntD    = cntQ;
        accD    = accQ;
        opndD   = opndQ;
        negD    = negQ;
        resultD = resultQ;
        dbzD    = dbzQ;
        if (flush) begin
            stateD = IDLE;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (in_valid) begin
                        opD  = op_sel;
                        negD = inIsRem ? signA : (signA ^ signB);
                        if (divZero) begin
                            resultD = inIsRem ? rs1 : '1;
                            dbzD    = 1'b1;
                            stateD  = DONE;
                        end else if (divOvf) begin
                            resultD = inIsRem ? '0 : MinVal;
                            dbzD    = 1'b0;
                            stateD  = DONE;
                        end else begin
                            accD   = {{WIDTH{1'b0}}, (inIsDiv ? magA : magB)};
                            opndD  = inIsDiv ? magB : magA;
                            cntD   = CNT_W'(WIDTH);
                            dbzD   = 1'b0;
                            stateD = CALC;
                        end
                    end
                end
                CALC: begin
                    accD = stepAcc;
                    cntD = cntQ - CNT_W'(1);
                    if (cntQ == CNT_W'(1)) begin
                        resultD = finalRes;
                        stateD  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        stateD = IDLE;
                    end
                end
                default: stateD = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= IDLE;
            opQ     <= MUL;
            cntQ    <= '0;
            accQ    <= '0;
            opndQ   <= '0;
            negQ    <= 1'b0;
            resultQ <= '0;
            dbzQ    <= 1'b0;
        end else begin
            stateQ  <= stateD;
            opQ     <= opD;
            cntQ    <= cntD;
            accQ    <= accD;
            opndQ   <= opndD;
            negQ    <= negD;
            resultQ <= resultD;
            dbzQ    <= dbzD;
        end
    end

    assign in_ready    = (stateQ == IDLE);
    assign out_valid   = (stateQ == DONE);
    assign md_out      = resultQ;
    assign div_by_zero = dbzQ;

endmodule

// File: tb/tb_smol_muldiv.sv
// Directed and randomised scoreboard bench for smol_muldiv at WIDTH=32.
module tb_smol_muldiv;
    import smol_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           lat;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    md_op_e       op_sel;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] md_out;
    logic         div_by_zero;

    exp_t sb[$];
    int   assertCount = 0;
    int   failCount   = 0;

    smol_muldiv #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_sel      (op_sel),
        .rs1         (rs1),
        .rs2         (rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .md_out      (md_out),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference semantics from native 64-bit arithmetic; returns {div_by_zero, result}.
    function automatic logic [W:0] model(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb64, ua, ub;
        logic [63:0]        p;
        logic [W-1:0]       r;
        logic               z;
        sa   = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        z    = 1'b0;
        r    = '0;
        p    = '0;
        case (op)
            MUL:    begin p = sa * sb64; r = p[31:0];  end
            MULH:   begin p = sa * sb64; r = p[63:32]; end
            MULHSU: begin p = sa * ub;   r = p[63:32]; end
            MULHU:  begin p = ua * ub;   r = p[63:32]; end
            DIV, REM: begin
                if (b == 0) begin
                    z = 1'b1;
                    r = (op == DIV) ? 32'hFFFF_FFFF : a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = (op == DIV) ? a : 32'd0;
                end else begin
                    p = (op == DIV) ? (sa / sb64) : (sa % sb64);
                    r = p[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    z = 1'b1;
                    r = (op == DIVU) ? 32'hFFFF_FFFF : a;
                end else begin
                    p = (op == DIVU) ? (ua / ub) : (ua % ub);
                    r = p[31:0];
                end
            end
        endcase
        return {z, r};
    endfunction

    // Drives one request for the accept edge and records what it must produce.
    task automatic applyStimulus(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] res, input logic dbz, input int lat,
                                 input string tag, input logic track);
        exp_t e;
        e.res = res;
        e.dbz = dbz;
        e.lat = lat;
        e.tag = tag;
        if (track) sb.push_back(e);
        in_valid = 1'b1;
        op_sel   = op;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_sel   = md_op_e'($urandom_range(0, 7));
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    // Called just after the accept edge; waits (bounded) for out_valid and scores it.
    task automatic collectResult();
        int   lat;
        exp_t e;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (sb.size() == 0) begin
            checkOutput("scoreboard underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            checkOutput({e.tag, " latency"}, 32'(lat), 32'(e.lat));
            checkOutput({e.tag, " md_out"}, md_out, e.res);
            checkOutput({e.tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        end
    endtask

    task automatic runOp(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic dbz, input int lat, input string tag);
        applyStimulus(op, a, b, res, dbz, lat, tag, 1'b1);
        collectResult();
        @(posedge clk);
        #1;
        checkOutput({tag, " back to idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, " md_out"}, md_out, 32'd0);
        checkOutput({tag, " div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    initial begin
        logic [W:0]   m;
        logic [W-1:0] a, b;
        md_op_e       op;
        logic         sawValid;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_sel    = MUL;
        rs1       = '0;
        rs2       = '0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed operations");
        runOp(MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, "MUL 7*-3");
        runOp(MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 33, "MULH min*min");
        runOp(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, "MULHSU");
        runOp(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, "MULHU");
        runOp(DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33, "DIV -7/2");
        runOp(REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 33, "REM -7/2");
        runOp(DIVU,   32'd100,        32'd7,         32'd14,        1'b0, 33, "DIVU 100/7");
        runOp(REMU,   32'd100,        32'd7,         32'd2,         1'b0, 33, "REMU 100/7");
        runOp(DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 1,  "DIVU 5/0");
        runOp(REM,    32'd5,          32'd0,         32'd5,         1'b1, 1,  "REM 5/0");
        runOp(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1,  "DIV min/-1");
        runOp(REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 1,  "REM min/-1");

        $display("[TB] randomised operations against reference model");
        for (int i = 0; i < 8; i++) begin
            op = md_op_e'(i);
            a  = $urandom;
            b  = (i == 5) ? 32'd0 : $urandom;
            m  = model(op, a, b);
            runOp(op, a, b, m[W-1:0], m[W], (m[W] ? 1 : 33), $sformatf("rand op%0d", i));
        end

        $display("[TB] backpressure in DONE");
        out_ready = 1'b0;
        applyStimulus(DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33, "bp DIVU", 1'b1);
        collectResult();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            op_sel   = MUL;
            rs1      = 32'd3;
            rs2      = 32'd3;
            @(posedge clk);
            #1;
            checkOutput("bp held md_out", md_out, 32'd14);
            checkOutput("bp in_ready low", {31'd0, in_ready}, 32'd0);
            checkOutput("bp out_valid held", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("bp release out_valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] flush mid-CALC");
        applyStimulus(MUL, 32'd7, 32'd3, 32'd0, 1'b0, 0, "flushed", 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush in_ready", {31'd0, in_ready}, 32'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) sawValid = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("flush no out_valid", {31'd0, sawValid}, 32'd0);

        // A request presented together with flush must be dropped.
        in_valid = 1'b1;
        flush    = 1'b1;
        op_sel   = DIVU;
        rs1      = 32'd9;
        rs2      = 32'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flush drops request", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("flush dropped no valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] reset mid-CALC");
        applyStimulus(DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 0, "reset killed", 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("mid reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        runOp(REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33, "post-reset REMU");

        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
